pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32I core. It owns a registered load scoreboard that replaces ID-local load tracking and generates the per-stage stall vector. It arbitrates between memory-busy, load-use and fetch-busy stall sources. It sequences IF/ID flushes for ID-resolved jumps, including discarding a wrong-path fetch that is still in flight.

Parameters:
NREG, 32, number of architectural registers (scoreboard depth); x0 never tracked
AW, 5, register address width, equal to clog2(NREG)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction (0 = bubble)
id_rs1_rd  in  1  ID reads rs1
id_rs1  in  AW  rs1 address
id_rs2_rd  in  1  ID reads rs2
id_rs2  in  AW  rs2 address
id_is_load  in  1  ID instruction is a load
id_rd  in  AW  ID destination
id_jump  in  1  ID resolved a taken JAL/JALR/branch this cycle
if_busy  in  1  instruction fetch outstanding, IF result not ready
mem_busy  in  1  MEM stage multi-cycle data access in progress
wb_load  in  1  WB is writing load data this cycle
wb_rd  in  AW  WB destination
stall  out  6  hold vector {wb,mem,ex,id,if,pc}; bit=1 holds that stage's register
flush_if_id  out  1  insert bubble into IF/ID register this cycle
load_stall  out  1  load-use hazard active (diagnostic)
sb_busy  out  NREG  scoreboard contents, bit i = load to xi pending

Behaviour:
- Reset (async, rst_n=0): scoreboard cleared, FSM=RUN, stall=0, flush_if_id=0, load_stall=0, sb_busy=0. This applies mid-operation as well; release is synchronous to clk.
- Clear mask: when wb_load=1 and wb_rd!=0, clr = bit wb_rd; otherwise clr = 0. Clear takes effect in the same cycle (the regfile is write-through).
- Hazard, combinational: an operand hazard exists when its read flag is 1, its address is !=0, and (sb & ~clr)[address]=1. load_stall = id_valid & (rs1 hazard | rs2 hazard).
- Stall priority, fixed:
  - mem_busy: stall=6'b011111; WB receives a bubble.
  - else load_stall: stall=6'b000111; EX receives a bubble.
  - else if_busy or FSM=DRAIN: stall=6'b000011; ID receives a bubble.
  - else stall=6'b000000.
- Scoreboard set: at the clock edge, when stall[2]=0, id_valid=1, id_is_load=1 and id_rd!=0, sb[id_rd] is set.
- Scoreboard clear: at the clock edge, sb[wb_rd] is cleared by clr.
- Set and clear on the same register in the same cycle: set wins (the new load is younger).
- id_jump is honoured only when stall[2]=0. While ID is held, ID re-presents the jump on a later cycle.
- FSM RUN:
  - Honoured jump with if_busy=0: flush_if_id=1 this cycle; FSM stays in RUN.
  - Honoured jump with if_busy=1: flush_if_id=1; next state is DRAIN.
- FSM DRAIN: the wrong-path fetch is still outstanding.
  - flush_if_id=1 every cycle.
  - When if_busy=0 is sampled, return to RUN. That cycle's fetched word is discarded by the flush.
- Latency: every output is combinational from the current inputs and state. Scoreboard updates are visible the cycle after the edge.
- Multiple loads to the same rd: a single bit is kept. The pipeline is in-order, so the bit clears at the first matching WB. The second load cannot issue before then because of WAW through the load-use check on its rd? Not required. Bench must not rely on overlap.

Optional Feature:
PIPE_HAZARD_CTRL_PERF_EN
- Defined: adds three 32-bit wrap-around counters with output ports perf_load_stall, perf_mem_stall and perf_flush.
  - perf_load_stall and perf_mem_stall count cycles in which the matching stall source is selected.
  - perf_flush counts cycles with flush_if_id=1.
  - All three counters reset to 0 on rst_n.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - STALL_NONE=6'b000000, STALL_FETCH=6'b000011, STALL_LOAD=6'b000111, STALL_MEM=6'b011111
  - stage bit indices (ST_PC=0 … ST_WB=5)
  - FSM encoding RUN=1'b0, DRAIN=1'b1
- Sub-module load_scoreboard holds:
  - the NREG-bit register with set/clear ports
  - set-wins priority
  - the two-port hazard lookup with clr bypass

Test Plan:
- Load-use: ID load rd=5; next cycle ID reads rs1=5 -> load_stall=1, stall=000111 until the cycle wb_load=1 with wb_rd=5, in which load_stall=0 (same-cycle bypass).
- x0 load: load rd=0, then a consumer of rs1=0 -> sb_busy stays 0 and no stall.
- Priority: mem_busy=1 together with a load hazard and if_busy=1 -> stall=011111; drop mem_busy -> stall=000111.
- Jump with no fetch outstanding: id_jump=1, if_busy=0 -> flush_if_id=1 for exactly 1 cycle, FSM stays RUN.
- Jump with fetch outstanding: id_jump=1 with if_busy=1 for 3 cycles -> flush_if_id=1 for 4 cycles total (jump cycle plus 3 DRAIN cycles), stall=000011 during DRAIN, then RUN.
- Async reset: set sb bits 3 and 7, enter DRAIN, assert rst_n=0 between edges -> sb_busy=0, stall=0 and flush_if_id=0 immediately. With PIPE_HAZARD_CTRL_PERF_EN defined, the counters also read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, stage bit indices and FSM encoding.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_FETCH = 6'b000011;
  localparam logic [5:0] STALL_LOAD  = 6'b000111;
  localparam logic [5:0] STALL_MEM   = 6'b011111;

  localparam int unsigned ST_PC  = 0;
  localparam int unsigned ST_IF  = 1;
  localparam int unsigned ST_ID  = 2;
  localparam int unsigned ST_EX  = 3;
  localparam int unsigned ST_MEM = 4;
  localparam int unsigned ST_WB  = 5;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/load_scoreboard.sv
// Pending-load scoreboard: one bit per register, set-wins update, two read ports that
// see a same-cycle WB clear (write-through regfile).
module load_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_rd,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_rd,
  input  logic            rs1_rd,
  input  logic [AW-1:0]   rs1,
  input  logic            rs2_rd,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_hazard,
  output logic            rs2_hazard,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] sb_q, sb_d;
  logic [NREG-1:0] set_mask, clr_mask, sb_eff;

  // Bit 0 of both masks stays zero so x0 is never tracked.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      set_mask[i] = set_en && (set_rd == AW'(i));
      clr_mask[i] = clr_en && (clr_rd == AW'(i));
    end
  end

  assign sb_eff = sb_q & ~clr_mask;
  assign sb_d   = sb_eff | set_mask;

  assign rs1_hazard = rs1_rd && (rs1 != '0) && sb_eff[rs1];
  assign rs2_hazard = rs2_rd && (rs2 != '0) && sb_eff[rs2];
  assign busy       = sb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline controller: load scoreboard, stall arbitration and IF/ID flush sequencing.
// Define PIPE_HAZARD_CTRL_PERF_EN to add stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_rs1_rd,
  input  logic [AW-1:0]   id_rs1,
  input  logic            id_rs2_rd,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_is_load,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_jump,
  input  logic            if_busy,
  input  logic            mem_busy,
  input  logic            wb_load,
  input  logic [AW-1:0]   wb_rd,
  output logic [5:0]      stall,
  output logic            flush_if_id,
  output logic            load_stall,
  output logic [NREG-1:0] sb_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_load_stall,
  output logic [31:0]     perf_mem_stall,
  output logic [31:0]     perf_flush
`endif
);

  ctrl_state_e state_q, state_d;
  logic        rs1_hazard, rs2_hazard;
  logic        sb_set;
  logic        jump_ok;

  load_scoreboard #(
    .NREG(NREG),
    .AW  (AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (sb_set),
    .set_rd    (id_rd),
    .clr_en    (wb_load),
    .clr_rd    (wb_rd),
    .rs1_rd    (id_rs1_rd),
    .rs1       (id_rs1),
    .rs2_rd    (id_rs2_rd),
    .rs2       (id_rs2),
    .rs1_hazard(rs1_hazard),
    .rs2_hazard(rs2_hazard),
    .busy      (sb_busy)
  );

  assign load_stall = id_valid && (rs1_hazard || rs2_hazard);

  always_comb begin
    stall = STALL_NONE;
    if (mem_busy) begin
      stall = STALL_MEM;
    end else if (load_stall) begin
      stall = STALL_LOAD;
    end else if (if_busy || (state_q == DRAIN)) begin
      stall = STALL_FETCH;
    end
  end

  // A held ID re-presents its load/jump later, so neither may take effect now.
  assign sb_set  = !stall[ST_ID] && id_valid && id_is_load;
  assign jump_ok = !stall[ST_ID] && id_jump;

  always_comb begin
    state_d     = state_q;
    flush_if_id = 1'b0;
    unique case (state_q)
      RUN: begin
        if (jump_ok) begin
          flush_if_id = 1'b1;
          if (if_busy) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The wrong-path fetch lands in the cycle if_busy drops; the flush discards it.
        flush_if_id = 1'b1;
        if (!if_busy) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_load_q, perf_mem_q, perf_flush_q;
  logic        mem_sel, load_sel;

  assign mem_sel  = mem_busy;
  assign load_sel = !mem_busy && load_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_q  <= '0;
      perf_mem_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      if (load_sel)    perf_load_q  <= perf_load_q + 32'd1;
      if (mem_sel)     perf_mem_q   <= perf_mem_q + 32'd1;
      if (flush_if_id) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_load_stall = perf_load_q;
  assign perf_mem_stall  = perf_mem_q;
  assign perf_flush      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, async-reset sequence and a randomized
// run against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid, id_rs1_rd, id_rs2_rd, id_is_load, id_jump;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        if_busy, mem_busy, wb_load;
  logic [5:0]  stall;
  logic        flush_if_id, load_stall;
  logic [31:0] sb_busy;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_load_stall, perf_mem_stall, perf_flush;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(
    .NREG(32),
    .AW  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1_rd  (id_rs1_rd),
    .id_rs1     (id_rs1),
    .id_rs2_rd  (id_rs2_rd),
    .id_rs2     (id_rs2),
    .id_is_load (id_is_load),
    .id_rd      (id_rd),
    .id_jump    (id_jump),
    .if_busy    (if_busy),
    .mem_busy   (mem_busy),
    .wb_load    (wb_load),
    .wb_rd      (wb_rd),
    .stall      (stall),
    .flush_if_id(flush_if_id),
    .load_stall (load_stall),
    .sb_busy    (sb_busy)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_load_stall(perf_load_stall),
    .perf_mem_stall (perf_mem_stall),
    .perf_flush     (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, r1rd;
    logic [4:0]  r1;
    logic        r2rd;
    logic [4:0]  r2;
    logic        ld;
    logic [4:0]  rd;
    logic        jmp, ifb, memb, wbl;
    logic [4:0]  wbrd;
    logic [5:0]  e_stall;
    logic        e_flush, e_ls;
    logic [31:0] e_sb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic r1rd, input int r1, input logic r2rd,
                     input int r2, input logic ld, input int rd, input logic jmp,
                     input logic ifb, input logic memb, input logic wbl, input int wbrd,
                     input logic [5:0] est, input logic efl, input logic els,
                     input logic [31:0] esb);
    vec_t t;
    t.valid = v;   t.r1rd = r1rd; t.r1 = 5'(r1); t.r2rd = r2rd; t.r2 = 5'(r2);
    t.ld = ld;     t.rd = 5'(rd); t.jmp = jmp;   t.ifb = ifb;   t.memb = memb;
    t.wbl = wbl;   t.wbrd = 5'(wbrd);
    t.e_stall = est; t.e_flush = efl; t.e_ls = els; t.e_sb = esb;
    tbl.push_back(t);
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs1_rd = 0; id_rs1 = 0; id_rs2_rd = 0; id_rs2 = 0;
    id_is_load = 0; id_rd = 0; id_jump = 0; if_busy = 0; mem_busy = 0;
    wb_load = 0; wb_rd = 0;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] es, input logic ef,
                            input logic el, input logic [31:0] esb);
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".flush"}, 32'(flush_if_id), 32'(ef));
    chk({tag, ".load_stall"}, 32'(load_stall), 32'(el));
    chk({tag, ".sb_busy"}, sb_busy, esb);
  endtask

  // Behavioural model state
  bit          pend[32];
  bit          draining;
  int unsigned m_load, m_mem, m_flush;

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_outs("reset", 6'h00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // v r1rd r1 r2rd r2 ld rd jmp ifb memb wbl wbrd | stall flush ls sb
    add(1,0,0,0,0,1,5,0,0,0,0,0, 6'h00,0,0,32'h0);      // load x5
    add(1,1,5,0,0,0,0,0,0,0,0,0, 6'h07,0,1,32'h20);     // load-use
    add(1,1,5,0,0,0,0,0,0,0,0,0, 6'h07,0,1,32'h20);
    add(1,1,5,0,0,0,0,0,0,0,1,5, 6'h00,0,0,32'h20);     // same-cycle WB bypass
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);
    add(1,0,0,0,0,1,0,0,0,0,0,0, 6'h00,0,0,32'h0);      // load x0
    add(1,1,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);
    add(1,0,0,0,0,1,7,0,0,0,0,0, 6'h00,0,0,32'h0);      // load x7
    add(1,0,0,1,7,0,0,0,1,1,0,0, 6'h1f,0,1,32'h80);     // mem beats load beats fetch
    add(1,0,0,1,7,0,0,0,1,0,0,0, 6'h07,0,1,32'h80);
    add(1,0,0,1,7,0,0,0,1,0,1,7, 6'h03,0,0,32'h80);
    add(1,0,0,0,0,0,0,1,0,0,0,0, 6'h00,1,0,32'h0);      // jump, no fetch pending
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);
    add(1,0,0,0,0,0,0,1,1,0,0,0, 6'h03,1,0,32'h0);      // jump, fetch pending
    add(0,0,0,0,0,0,0,0,1,0,0,0, 6'h03,1,0,32'h0);
    add(0,0,0,0,0,0,0,0,1,0,0,0, 6'h03,1,0,32'h0);
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h03,1,0,32'h0);      // fetch lands, discarded
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);
    add(1,0,0,0,0,1,9,0,0,0,0,0, 6'h00,0,0,32'h0);      // load x9
    add(1,1,9,0,0,0,0,1,0,0,0,0, 6'h07,0,1,32'h200);    // jump held by load-use
    add(1,1,9,0,0,0,0,1,0,0,1,9, 6'h00,1,0,32'h200);
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);
    add(1,0,0,0,0,1,4,0,0,0,0,0, 6'h00,0,0,32'h0);      // load x4
    add(1,0,0,0,0,1,4,0,0,0,1,4, 6'h00,0,0,32'h10);     // set wins over clear
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h10);
    add(0,0,0,0,0,0,0,0,0,0,1,4, 6'h00,0,0,32'h10);
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);
    add(1,0,0,0,0,1,6,0,0,1,0,0, 6'h1f,0,0,32'h0);      // load held by mem_busy
    add(0,0,0,0,0,0,0,0,0,0,0,0, 6'h00,0,0,32'h0);

    foreach (tbl[i]) begin
      @(negedge clk);
      id_valid = tbl[i].valid; id_rs1_rd = tbl[i].r1rd; id_rs1 = tbl[i].r1;
      id_rs2_rd = tbl[i].r2rd; id_rs2 = tbl[i].r2; id_is_load = tbl[i].ld;
      id_rd = tbl[i].rd; id_jump = tbl[i].jmp; if_busy = tbl[i].ifb;
      mem_busy = tbl[i].memb; wb_load = tbl[i].wbl; wb_rd = tbl[i].wbrd;
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_ls,
                 tbl[i].e_sb);
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    @(negedge clk);
    drive_idle();
    #1;
    chk("perf_load_tbl", perf_load_stall, 32'd4);
    chk("perf_mem_tbl", perf_mem_stall, 32'd2);
    chk("perf_flush_tbl", perf_flush, 32'd6);
`endif

    // Async reset while in DRAIN with scoreboard bits 3 and 7 set
    @(negedge clk);
    drive_idle(); id_valid = 1; id_is_load = 1; id_rd = 5'd3;
    @(negedge clk);
    id_rd = 5'd7;
    @(negedge clk);
    drive_idle(); id_valid = 1; id_jump = 1; if_busy = 1;
    #1;
    chk("rst_seq.jump_flush", 32'(flush_if_id), 32'd1);
    @(negedge clk);
    drive_idle();
    #1;
    check_outs("rst_seq.drain", 6'h03, 1'b1, 1'b0, 32'h88);
    rst_n = 1'b0;
    #1;
    check_outs("rst_seq.async", 6'h00, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("rst_seq.perf_load", perf_load_stall, 32'd0);
    chk("rst_seq.perf_mem", perf_mem_stall, 32'd0);
    chk("rst_seq.perf_flush", perf_flush, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model
    foreach (pend[r]) pend[r] = 0;
    draining = 0; m_load = 0; m_mem = 0; m_flush = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] e_sb;
      logic [5:0]  e_stall;
      bit          h1, h2, e_ls, held, e_fl;
      @(negedge clk);
      id_valid   = ($urandom_range(0, 9) < 8);
      id_rs1_rd  = ($urandom_range(0, 1) == 1);
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2_rd  = ($urandom_range(0, 1) == 1);
      id_rs2     = 5'($urandom_range(0, 7));
      id_is_load = ($urandom_range(0, 2) == 0);
      id_rd      = 5'($urandom_range(0, 7));
      id_jump    = ($urandom_range(0, 6) == 0);
      if_busy    = ($urandom_range(0, 9) < 3);
      mem_busy   = ($urandom_range(0, 9) < 2);
      wb_load    = ($urandom_range(0, 2) == 0);
      wb_rd      = 5'($urandom_range(0, 7));
      #1;
      // A pending load is invisible to readers if WB is writing it right now.
      h1 = id_rs1_rd && id_rs1 != 0 && pend[id_rs1] && !(wb_load && wb_rd == id_rs1);
      h2 = id_rs2_rd && id_rs2 != 0 && pend[id_rs2] && !(wb_load && wb_rd == id_rs2);
      e_ls = id_valid && (h1 || h2);
      if (mem_busy) e_stall = 6'b011111;
      else if (e_ls) e_stall = 6'b000111;
      else if (if_busy || draining) e_stall = 6'b000011;
      else e_stall = 6'b000000;
      held = mem_busy || e_ls;
      e_fl = draining || (id_jump && !held);
      e_sb = '0;
      for (int r = 0; r < 32; r++) e_sb[r] = pend[r];
      check_outs($sformatf("rand%0d", cyc), e_stall, e_fl, e_ls, e_sb);
      // Model update for the coming edge
      if (mem_busy) m_mem++;
      else if (e_ls) m_load++;
      if (e_fl) m_flush++;
      if (draining) draining = if_busy;
      else draining = id_jump && !held && if_busy;
      if (wb_load && wb_rd != 0) pend[wb_rd] = 0;
      if (!held && id_valid && id_is_load && id_rd != 0) pend[id_rd] = 1;
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    @(negedge clk);
    drive_idle();
    #1;
    chk("perf_load_rand", perf_load_stall, 32'(m_load));
    chk("perf_mem_rand", perf_mem_stall, 32'(m_mem));
    chk("perf_flush_rand", perf_flush, 32'(m_flush));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
